// File: rtl/fft_frame_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : fft_frame_controller_if
// Purpose  : Bundles the sample stream, FFT core link and result stream
//            signals of the FFT frame controller.
// Revision : 1.0  initial release
// ============================================================================
interface fft_frame_controller_if #(
  parameter int N        = 8,
  parameter int NUM_SIZE = 32
);
  // upstream sample stream
  logic                  in_valid;
  logic                  in_ready;
  logic [NUM_SIZE-1:0]   in_data;
  // FFT core link
  logic [NUM_SIZE*N-1:0] fft_frame;
  logic                  fft_start;
  logic                  fft_done;
  logic [NUM_SIZE*N-1:0] fft_result;
  // downstream result stream
  logic                  out_valid;
  logic                  out_ready;
  logic [NUM_SIZE-1:0]   out_data;
  logic                  out_last;

  // controller side
  modport slave (
    input  in_valid, in_data, fft_done, fft_result, out_ready,
    output in_ready, fft_frame, fft_start, out_valid, out_data, out_last
  );

  // environment side (source, FFT core, sink)
  modport master (
    output in_valid, in_data, fft_done, fft_result, out_ready,
    input  in_ready, fft_frame, fft_start, out_valid, out_data, out_last
  );
endinterface
`default_nettype wire

// File: rtl/fft_frame_controller.sv
`default_nettype none
// ============================================================================
// Module   : fft_frame_controller
// Purpose  : Loads N samples straight into bit-reversed frame slots, launches
//            the FFT core, captures its result and streams it out in order.
// Revision : 1.0  initial release
// ============================================================================
module fft_frame_controller #(
  parameter int N        = 8,
  parameter int NUM_SIZE = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  fft_frame_controller_if.slave  bus
);

  localparam int            IW       = $clog2(N);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    START  = 2'd1,
    WAIT   = 2'd2,
    UNLOAD = 2'd3
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [IW-1:0]       in_cnt;
  logic [IW-1:0]       out_cnt;
  logic [NUM_SIZE-1:0] frame_mem  [N];
  logic [NUM_SIZE-1:0] result_mem [N];
  logic                in_fire;
  logic                out_fire;

  // Reverse the IW index bits so sample k lands in its FFT input slot.
  function automatic logic [IW-1:0] bitrev(input logic [IW-1:0] k);
    logic [IW-1:0] r;
    r = '0;
    for (int b = 0; b < IW; b++) begin
      r[b] = k[IW-1-b];
    end
    return r;
  endfunction

  assign in_fire  = (state == LOAD)   && bus.in_valid;
  assign out_fire = (state == UNLOAD) && bus.out_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LOAD;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode; done pulses outside WAIT fall through unhandled.
  always_comb begin
    state_next = state;
    case (state)
      LOAD:    if (in_fire && (in_cnt == LAST_IDX))   state_next = START;
      START:   state_next = WAIT;
      WAIT:    if (bus.fft_done)                      state_next = UNLOAD;
      UNLOAD:  if (out_fire && (out_cnt == LAST_IDX)) state_next = LOAD;
      default: state_next = LOAD;
    endcase
  end

  // Input sample counter; clears explicitly on the last sample of a frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_cnt <= '0;
    end else if (in_fire) begin
      in_cnt <= (in_cnt == LAST_IDX) ? '0 : in_cnt + IW'(1);
    end
  end

  // Frame store; only written in LOAD, so it is frozen while the core runs.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < N; j++) begin
        frame_mem[j] <= '0;
      end
    end else if (in_fire) begin
      frame_mem[bitrev(in_cnt)] <= bus.in_data;
    end
  end

  // Result capture on the completion pulse seen in WAIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < N; j++) begin
        result_mem[j] <= '0;
      end
    end else if ((state == WAIT) && bus.fft_done) begin
      for (int j = 0; j < N; j++) begin
        result_mem[j] <= bus.fft_result[j*NUM_SIZE +: NUM_SIZE];
      end
    end
  end

  // Output element counter; clears explicitly on the last transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_cnt <= '0;
    end else if (out_fire) begin
      out_cnt <= (out_cnt == LAST_IDX) ? '0 : out_cnt + IW'(1);
    end
  end

  // Outputs decode only registered state, so no input-to-output paths exist.
  assign bus.in_ready  = (state == LOAD);
  assign bus.fft_start = (state == START);
  assign bus.out_valid = (state == UNLOAD);
  assign bus.out_data  = result_mem[out_cnt];
  assign bus.out_last  = (state == UNLOAD) && (out_cnt == LAST_IDX);

  generate
    for (genvar j = 0; j < N; j++) begin : g_pack_frame
      assign bus.fft_frame[j*NUM_SIZE +: NUM_SIZE] = frame_mem[j];
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_fft_frame_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_fft_frame_controller
// Purpose  : Directed, table-driven self-checking bench for the FFT frame
//            controller (N=8, 32-bit elements).
// Revision : 1.0  initial release
// ============================================================================
module tb_fft_frame_controller;

  typedef logic [7:0][31:0] vec8_t;

  typedef struct {
    vec8_t vals;        // samples in arrival order
    bit    gaps;        // insert an in_valid=0 cycle after each sample
    vec8_t exp_frame;   // expected fft_frame, slot j = element j
    vec8_t res;         // FFT core result presented on fft_done
    int    done_delay;  // cycles from fft_start to fft_done
    int    stall_idx;   // element held under backpressure
    int    stall_len;   // backpressure cycles on that element
    bit    early_done;  // stray fft_done pulse during LOAD
    bit    check_gap;   // frame follows the previous one back-to-back
  } rec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   xfer_cnt = 0;
  int   last_out_cyc = 0;
  int   start_cyc = 0;
  rec_t tbl [4];

  fft_frame_controller_if #(.N(8), .NUM_SIZE(32)) bus ();

  fft_frame_controller #(.N(8), .NUM_SIZE(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Cycle bookkeeping for transfer counts and frame-to-frame spacing.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.out_valid && bus.out_ready) begin
      xfer_cnt <= xfer_cnt + 1;
      if (bus.out_last) last_out_cyc <= cyc;
    end
    if (bus.fft_start) start_cyc <= cyc;
  end

  function automatic vec8_t mk8(input logic [31:0] a0, a1, a2, a3, a4, a5, a6, a7);
    vec8_t r;
    r[0] = a0; r[1] = a1; r[2] = a2; r[3] = a3;
    r[4] = a4; r[5] = a5; r[6] = a6; r[7] = a7;
    return r;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Runs one frame; entered and left at a falling edge.
  task automatic run_frame(input rec_t r);
    int base;
    int idx;
    int scnt;
    for (int i = 0; i < 8; i++) begin
      chk("in_ready_load", bus.in_ready, 1'b1);
      chk("no_start_load", bus.fft_start, 1'b0);
      chk("no_valid_load", bus.out_valid, 1'b0);
      bus.fft_done = (r.early_done && i == 2);
      bus.in_valid = 1'b1;
      bus.in_data  = r.vals[i];
      @(negedge clk);
      bus.fft_done = 1'b0;
      if (r.gaps && i < 7) begin
        bus.in_valid = 1'b0;
        bus.in_data  = 32'hBAD0_0000 | 32'(i);
        chk("in_ready_gap", bus.in_ready, 1'b1);
        @(negedge clk);
      end
    end
    bus.in_valid = 1'b0;
    chk("fft_start_pulse", bus.fft_start, 1'b1);
    chk("in_ready_start", bus.in_ready, 1'b0);
    chk("frame_bitrev", bus.fft_frame, r.exp_frame);
    @(negedge clk);
    chk("fft_start_one_cycle", bus.fft_start, 1'b0);
    if (r.check_gap) chk("frame_spacing", 256'(start_cyc - last_out_cyc), 256'd9);
    for (int k = 1; k < r.done_delay; k++) begin
      chk("no_valid_wait", bus.out_valid, 1'b0);
      chk("in_ready_wait", bus.in_ready, 1'b0);
      chk("frame_held", bus.fft_frame, r.exp_frame);
      @(negedge clk);
    end
    bus.fft_done   = 1'b1;
    bus.fft_result = r.res;
    @(negedge clk);
    bus.fft_done   = 1'b0;
    bus.fft_result = {8{32'hFFFF_FFFF}};
    chk("out_valid_after_done", bus.out_valid, 1'b1);
    base = xfer_cnt;
    idx  = 0;
    scnt = 0;
    while (idx < 8) begin
      chk("out_valid_unload", bus.out_valid, 1'b1);
      chk("out_data", bus.out_data, r.res[idx]);
      chk("out_last", bus.out_last, (idx == 7));
      if (idx == r.stall_idx && scnt < r.stall_len) begin
        bus.out_ready = 1'b0;
        scnt++;
      end else begin
        bus.out_ready = 1'b1;
        idx++;
      end
      @(negedge clk);
    end
    bus.out_ready = 1'b0;
    chk("xfer_count", 256'(xfer_cnt - base), 256'd8);
    chk("in_ready_after_unload", bus.in_ready, 1'b1);
    chk("no_valid_after_unload", bus.out_valid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // bit-reversed fill, early done, backpressure on element 2
    tbl[0] = '{vals: mk8(0, 1, 2, 3, 4, 5, 6, 7), gaps: 1'b0,
               exp_frame: mk8(0, 4, 2, 6, 1, 5, 3, 7),
               res: mk8(100, 101, 102, 103, 104, 105, 106, 107),
               done_delay: 5, stall_idx: 2, stall_len: 3,
               early_done: 1'b1, check_gap: 1'b0};
    // valid gaps, earliest legal done
    tbl[1] = '{vals: mk8(10, 11, 12, 13, 14, 15, 16, 17), gaps: 1'b1,
               exp_frame: mk8(10, 14, 12, 16, 11, 15, 13, 17),
               res: mk8(200, 201, 202, 203, 204, 205, 206, 207),
               done_delay: 1, stall_idx: 0, stall_len: 0,
               early_done: 1'b0, check_gap: 1'b0};
    // fresh frame after a mid-load reset, stall on the last element
    tbl[2] = '{vals: mk8(20, 21, 22, 23, 24, 25, 26, 27), gaps: 1'b0,
               exp_frame: mk8(20, 24, 22, 26, 21, 25, 23, 27),
               res: mk8(300, 301, 302, 303, 304, 305, 306, 307),
               done_delay: 3, stall_idx: 7, stall_len: 2,
               early_done: 1'b0, check_gap: 1'b0};
    // back-to-back with the previous frame
    tbl[3] = '{vals: mk8(30, 31, 32, 33, 34, 35, 36, 37), gaps: 1'b0,
               exp_frame: mk8(30, 34, 32, 36, 31, 35, 33, 37),
               res: mk8(400, 401, 402, 403, 404, 405, 406, 407),
               done_delay: 2, stall_idx: 0, stall_len: 0,
               early_done: 1'b0, check_gap: 1'b1};

    rst            = 1'b1;
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.fft_done   = 1'b0;
    bus.fft_result = '0;
    bus.out_ready  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1'b1);
    chk("rst_fft_start", bus.fft_start, 1'b0);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_out_last", bus.out_last, 1'b0);
    chk("rst_out_data", bus.out_data, 32'd0);
    chk("rst_fft_frame", bus.fft_frame, 256'd0);
    rst = 1'b0;
    @(negedge clk);

    run_frame(tbl[0]);
    run_frame(tbl[1]);

    // mid-load reset: five samples, then reset, then a stray done
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 32'd50 + 32'(i);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    rst          = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_in_ready", bus.in_ready, 1'b1);
    chk("midrst_fft_start", bus.fft_start, 1'b0);
    chk("midrst_frame", bus.fft_frame, 256'd0);
    chk("midrst_out_valid", bus.out_valid, 1'b0);
    bus.fft_done = 1'b1;
    @(negedge clk);
    bus.fft_done = 1'b0;
    chk("stray_done_in_ready", bus.in_ready, 1'b1);
    chk("stray_done_out_valid", bus.out_valid, 1'b0);

    run_frame(tbl[2]);
    run_frame(tbl[3]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fft_frame_controller.md
# fft_frame_controller

Sequencing controller for the FFT datapath. It accepts one sample per handshake from an upstream stream and writes each sample directly into its bit-reversed slot of a frame register, so no separate reordering stage is needed. It launches the FFT core on the complete frame, waits for completion, captures the result, and streams it out one element per handshake. It sits between the sample source and the combinational/multi-cycle FFT core.

## Interface
- N, 8: points per frame; power of two, ≥2; index width IW = $clog2(N)
- NUM_SIZE, 32: bits per element (complex packed, opaque to this block)

- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  upstream sample valid
- in_ready  out  1  block can accept a sample
- in_data  in  NUM_SIZE  upstream sample
- fft_frame  out  NUM_SIZE*N  frame to FFT core, bit-reversed order, slot j at [j*NUM_SIZE +: NUM_SIZE]
- fft_start  out  1  one-cycle launch pulse to FFT core
- fft_done  in  1  FFT core completion pulse
- fft_result  in  NUM_SIZE*N  FFT core output, natural order, sampled on fft_done
- out_valid  out  1  output element valid
- out_ready  in  1  downstream accepts element
- out_data  out  NUM_SIZE  output element
- out_last  out  1  high with element N-1 of a frame

One clock; reset is synchronous and active-high.

## Operation
- States: LOAD, START, WAIT, UNLOAD. Reset state is LOAD.
- LOAD
  - in_ready=1.
  - Accept when in_valid&in_ready. The k-th accepted sample (k=0..N-1, counter in_cnt) is written to slot bitrev(k), where bitrev reverses the IW bits of k.
  - On the accept with in_cnt=N-1: in_cnt←0 and the next state is START.
- START: fft_start=1 for exactly this cycle; in_ready=0; next state WAIT.
- WAIT
  - in_ready=0. On fft_done=1, capture fft_result into the result register; next state UNLOAD.
  - fft_done observed in any state other than WAIT is ignored.
  - fft_frame is held constant from the START cycle through the WAIT exit.
- UNLOAD
  - out_valid=1; out_data=result slot out_cnt; out_last=(out_cnt==N-1).
  - On out_valid&out_ready, out_cnt increments. On the transfer with out_cnt=N-1: out_cnt←0 and the next state is LOAD.
  - out_data and out_last stay stable while out_valid=1 and out_ready=0.
- in_ready=0 in START, WAIT and UNLOAD. There is no input/output overlap: the next frame loads only after unload completes.
- Counters are IW bits wide and wrap only via the explicit reset-to-0 on the last element.
- Reset, including mid-frame: state←LOAD, in_cnt←0, out_cnt←0, frame and result registers←0.
  - Partially loaded samples are discarded.
  - A pending fft_done after reset is ignored because the state is not WAIT.

## Timing
- All outputs are registered or decoded from registered state only. There is no combinational path from in_valid, out_ready or fft_done to any output.
- Output values during and directly after reset: in_ready=1 (LOAD), fft_start=0, out_valid=0, out_last=0, out_data=0, fft_frame=0.
- Throughput in LOAD is one sample per cycle with in_valid held high.
- The last sample is accepted at cycle t. Then fft_start=1 at t+1, and the state is WAIT from t+2.
- fft_done is sampled at cycle d (in WAIT). Then out_valid=1 at d+1.
- An FFT core that asserts done combinationally with start is not supported; the earliest honoured fft_done is cycle t+2.
- Last output transfer at cycle u. Then in_ready=1 at u+1.
- Minimum frame period with no stalls: N (load) + 1 (start) + 1 (earliest done) + N (unload) cycles.

## Test plan
- **Bit-reverse fill:** N=8, inputs 0..7 back-to-back. At fft_start, slots 0..7 of fft_frame must equal 0,4,2,6,1,5,3,7. fft_start must be high for exactly 1 cycle, 1 cycle after the 8th accept.
- **Input gaps:** in_valid toggled 1,0,1,0… with values 10..17. fft_frame must match slots bitrev order (10,14,12,16,11,15,13,17). in_cnt must not advance on in_valid=0 cycles.
- **Done handling:** pulse fft_done during LOAD, then 5 cycles after fft_start with fft_result = slots 100..107.
  - The early pulse must cause no state change.
  - out_valid must rise 1 cycle after the real pulse.
  - Outputs must be 100..107 in order, with out_last only on 107.
- **Backpressure:** out_ready low for 3 cycles on element 2. out_data must stay 102 and out_valid must stay 1. Exactly 8 transfers must occur, then in_ready=1 the next cycle.
- **Reset mid-load:** accept 5 samples, assert rst for 1 cycle, then load 8 new samples 20..27.
  - fft_frame must contain only the new samples in bitrev order.
  - in_ready must be 1 and fft_start must be 0 right after reset.
- **Back-to-back frames:** two frames streamed with out_ready=1. The second fft_start must occur at least 8 cycles after the first frame's out_last transfer completes. There must be no data mixing between frames.
